// File: rtl/ir_loader.sv
// rtl/ir_loader.sv - byte-stream program loader for the instruction memory
module ir_loader #(
  parameter int IR_MEM_SIZE = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] loaded_words
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_shift;

  logic        w_accept;
  logic        w_can_start;
  logic        w_arm;
  logic [15:0] w_len;
  logic        w_len_zero;
  logic        w_len_over;
  logic        w_word_end;
  logic        w_last_word;

  // in_ready comes from the registered state only; ERR keeps draining the link
  assign in_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                    (r_state == S_DATA)   || (r_state == S_ERR);

  assign w_accept    = in_valid & in_ready;
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_arm       = start & w_can_start;

  // Full count as it completes on the low-byte transfer
  assign w_len      = {r_count[15:8], in_data};
  assign w_len_zero = (w_len == 16'd0);
  assign w_len_over = (32'(w_len) > 32'(IR_MEM_SIZE));

  assign w_word_end  = (r_state == S_DATA) && w_accept && (r_byte_idx == 2'd3);
  assign w_last_word = w_word_end && (r_word_idx == (r_count - 16'd1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (in_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (in_valid) begin
          if (w_len_zero)      w_next = S_DONE;
          else if (w_len_over) w_next = S_ERR;
          else                 w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last_word) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Count capture, word assembly, write port and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= 16'd0;
      r_word_idx   <= 16'd0;
      r_byte_idx   <= 2'd0;
      r_shift      <= 24'd0;
      wr_en        <= 1'b0;
      wr_addr      <= 32'd0;
      wr_data      <= 32'd0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      loaded_words <= 16'd0;
    end else begin
      wr_en <= 1'b0;
      if (w_arm) begin
        r_word_idx   <= 16'd0;
        r_byte_idx   <= 2'd0;
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
        loaded_words <= 16'd0;
      end else if (w_accept) begin
        unique case (r_state)
          S_LEN_HI: r_count[15:8] <= in_data;
          S_LEN_LO: begin
            r_count[7:0] <= in_data;
            if (w_len_zero) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (w_len_over) begin
              err      <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_word_end) begin
              wr_en        <= 1'b1;
              wr_data      <= {r_shift, in_data};
              wr_addr      <= {14'd0, r_word_idx, 2'b00};
              r_word_idx   <= r_word_idx + 16'd1;
              loaded_words <= loaded_words + 16'd1;
              if (w_last_word) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end
            end else begin
              r_shift <= {r_shift[15:0], in_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_loader.sv
// tb/tb_ir_loader.sv - self-checking bench for ir_loader
module tb_ir_loader;

  localparam int MEM = 1000;
  localparam int SEND_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] loaded_words;

  ir_loader #(.IR_MEM_SIZE(MEM)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    logic        dn;
    logic        hold;
  } wr_t;

  typedef struct {
    int len;
    int mode;       // 0 valid always, 1 toggle, 2 random
    bit fixed;      // use the reference program bytes
    int extra;      // bytes sent after an over-size count
    bit mid_start;  // pulse start while in DATA
    bit exp_done;
    bit exp_err;
    int exp_words;
  } vec_t;

  wr_t  wq[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] plan [12] = '{8'h01, 8'h09, 8'h58, 8'h20, 8'h01, 8'h49, 8'h60, 8'h22,
                             8'h08, 8'h00, 8'h00, 8'h03};

  // Write monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (wr_en) wq.push_back('{wr_addr, wr_data, cyc, done, cpu_hold});
  end

  function automatic void chk(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input int mode);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    logic rdy;
    while (i < b.size() && guard < SEND_LIMIT) begin
      @(negedge clk);
      if ((mode == 1 && ph) || (mode == 2 && ($urandom % 2 == 0))) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b[i];
      end
      ph  = ~ph;
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) i++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("send_completed", (guard < SEND_LIMIT), 1);
  endtask

  task automatic run_case(input vec_t v);
    logic [7:0] b[$];
    int n_exp;
    bit model_err;
    pulse_start();
    chk("arm_in_ready", in_ready, 1);
    chk("arm_cpu_hold", cpu_hold, 1);
    chk("arm_done_clr", done, 0);
    chk("arm_err_clr", err, 0);
    chk("arm_loaded_clr", loaded_words, 0);
    wq.delete();
    model_err = (v.len > MEM);
    n_exp = model_err ? 0 : v.len;
    b.push_back(8'(v.len >> 8));
    b.push_back(8'(v.len));
    if (model_err) begin
      for (int i = 0; i < v.extra; i++) b.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < 4 * v.len; i++)
        b.push_back(v.fixed ? plan[i % 12] : 8'($urandom));
    end
    if (v.mid_start) begin
      fork
        send(b, v.mode);
        begin
          repeat (10) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      join
    end else begin
      send(b, v.mode);
    end
    repeat (3) @(negedge clk);
    chk("done", done, v.exp_done);
    chk("err", err, v.exp_err);
    chk("cpu_hold_end", cpu_hold, 0);
    chk("loaded_words", loaded_words, v.exp_words);
    if (model_err) chk("err_in_ready", in_ready, 1);
    chk("write_count", wq.size(), n_exp);
    for (int i = 0; i < n_exp && i < wq.size(); i++) begin
      chk("wr_addr", wq[i].addr, 4 * i);
      chk("wr_data", wq[i].data, {b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
      chk("done_at_wr", wq[i].dn, (i == n_exp - 1));
      chk("hold_at_wr", wq[i].hold, (i != n_exp - 1));
      if (i > 0 && v.mode < 2)
        chk("wr_spacing", wq[i].cyc - wq[i-1].cyc, (v.mode == 0) ? 4 : 8);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    logic [7:0] b[$];
    tbl[0] = '{3,       0, 1, 0,  0, 1, 0, 3};
    tbl[1] = '{3,       1, 1, 0,  0, 1, 0, 3};
    tbl[2] = '{0,       0, 0, 0,  0, 1, 0, 0};
    tbl[3] = '{1001,    0, 0, 20, 0, 0, 1, 0};
    tbl[4] = '{1,       2, 0, 0,  0, 1, 0, 1};
    tbl[5] = '{1000,    0, 0, 0,  0, 1, 0, 1000};
    tbl[6] = '{16'hFFFF,1, 0, 5,  0, 0, 1, 0};
    tbl[7] = '{5,       2, 0, 0,  0, 1, 0, 5};
    tbl[8] = '{4,       0, 0, 0,  1, 1, 0, 4};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_loaded", loaded_words, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 9; t++) run_case(tbl[t]);

    for (int r = 0; r < 6; r++) begin
      int l;
      l = int'($urandom_range(1, 12));
      run_case('{l, 2, 0, 0, 0, 1, 0, l});
    end

    // Reset in the middle of the second word
    pulse_start();
    wq.delete();
    b.delete();
    b.push_back(8'h00);
    b.push_back(8'h02);
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    send(b, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_cpu_hold", cpu_hold, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_loaded", loaded_words, 0);
    repeat (3) @(negedge clk);
    chk("midrst_write_count", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("midrst_addr0", wq[0].addr, 0);
      chk("midrst_data0", wq[0].data, {b[2], b[3], b[4], b[5]});
    end
    rst = 1'b0;
    run_case('{2, 0, 0, 0, 0, 1, 0, 2});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ir_loader.md
# ir_loader

Program loader for the instruction memory: a byte-serial valid/ready stream carries a 16-bit word count followed by big-endian instruction words, which the block assembles and writes through the instruction memory write port at consecutive word-aligned byte addresses. It sits between the host/debug byte link and the instruction memory, and holds the CPU stalled (`cpu_hold`) while a program is being loaded. It is the writer counterpart to the PC-indexed instruction read path.

## Interface
- `IR_MEM_SIZE`, 1000: instruction memory depth in 32-bit words; a word count above this is rejected.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that arms a new load; honoured in IDLE, DONE and ERR, ignored otherwise.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts a byte this cycle; a byte transfers when `in_valid & in_ready`.
- `wr_en` output 1: one-cycle instruction memory write strobe.
- `wr_addr` output 32: byte address, always a multiple of 4 (word_index << 2, same addressing as PC).
- `wr_data` output 32: instruction word.
- `cpu_hold` output 1: CPU stall, high from arm to DONE or ERR.
- `done` output 1: load completed; held until the next `start` or reset.
- `err` output 1: word count exceeded `IR_MEM_SIZE`; held until the next `start` or reset.
- `loaded_words` output 16: number of words written in the current or last load.

## Operation
- States:
  - IDLE: `in_ready`=0.
  - LEN_HI: `in_ready`=1; accepts count[15:8].
  - LEN_LO: `in_ready`=1; accepts count[7:0].
  - DATA: `in_ready`=1; accepts instruction bytes.
  - DONE: `in_ready`=0.
  - ERR: `in_ready`=1; drains and discards all bytes.
- On `start` in IDLE/DONE/ERR:
  - Go to LEN_HI.
  - Clear `done`, `err`, `loaded_words`, byte index and word index.
  - Set `cpu_hold`.
- LEN_LO accept:
  - count == 0: go to DONE.
  - count > `IR_MEM_SIZE`: go to ERR.
  - otherwise: go to DATA.
- DATA byte assembly:
  - Bytes are big-endian: first byte → [31:24], fourth byte → [7:0].
  - A 2-bit byte index wraps 3→0.
- On acceptance of the 4th byte of a word:
  - Register `wr_data` = assembled word and `wr_addr` = word_index*4.
  - Pulse `wr_en`.
  - Increment the word index and `loaded_words`.
- When the 4th byte of word count-1 is accepted: go to DONE. `done`=1, `cpu_hold`=0.
- ERR: `err`=1, `cpu_hold`=0. `in_ready` stays 1 so the link never deadlocks. No writes occur.
- `start` while in LEN_HI/LEN_LO/DATA is ignored. The load continues.
- `in_valid` low in any accepting state: hold state and partial word unchanged (stall tolerated indefinitely).
- Word index width: 16 bits. `wr_addr` is zero-extended to 32 bits.

## Timing
- Reset values (asynchronous, effective immediately):
  - state = IDLE.
  - `in_ready`, `wr_en`, `cpu_hold`, `done`, `err` = 0.
  - `wr_addr`, `wr_data` = 0; `loaded_words` = 0.
- `in_ready` is decoded from the registered state only, with no combinational path from `in_valid`.
- `start` at edge k: `in_ready`=1 and `cpu_hold`=1 from cycle k+1.
- Write latency: 4th byte accepted at edge k → `wr_en`=1 during cycle k+1 only, with `wr_addr`/`wr_data` stable. Those two outputs hold their values after the strobe.
- Final word: `wr_en` and `done` both become 1 in the same cycle k+1, and `cpu_hold` falls in that cycle. `done` stays 1 afterwards.
- Sustained throughput: one byte per cycle, so one write every 4 cycles.
- Reset mid-load: the load is aborted immediately. No further `wr_en`. Words already written stay in memory.

## Test plan
- Count 0x0003, then bytes 01 09 58 20 / 01 49 60 22 / 08 00 00 03 with `in_valid` held high → writes (0x0,0x01095820), (0x4,0x01496022), (0x8,0x08000003), each `wr_en` one cycle apart by 4. `done`=1 and `cpu_hold`=0 together with the third `wr_en`. `loaded_words`=3.
- Same stream with `in_valid` toggling 1/0 every cycle → identical writes, each 8 cycles apart. No duplicate or skipped strobes.
- Count 0x0000 → DONE right after the second byte. No `wr_en`. `done`=1, `loaded_words`=0.
- Count 0x03E9 (1001), `IR_MEM_SIZE`=1000 → `err`=1, `cpu_hold`=0, no `wr_en`. The 20 following bytes are all accepted (`in_ready`=1). A `start` pulse then clears `err` and enters LEN_HI.
- Count 0x0002, `rst` asserted after 6 data bytes → outputs go to reset values within the same cycle. Only the word at 0x0 was written. A new `start` and full load then succeed.
- `start` pulsed during DATA → ignored; the load completes with the original count and addresses.
